// File: rtl/prewish_pkg.sv
// Shared encodings and sizing helpers for the prewish mentor queue.
package prewish_pkg;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_HELD = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'b00,
    O_REQ  = 2'b01,
    O_GAP  = 2'b11
  } out_state_t;

  // Occupancy needs one extra bit so that a full queue (level == depth) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/prewish_fifo.sv
// Circular-buffer queue holding {address, data} words between the student side and the bus side.
module prewish_fifo
  import prewish_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A write into a full queue is only legal when the head leaves in the same cycle;
  // the freed slot is the one the write pointer already points at.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign dout = mem[rd_ptr];

  always_ff @(posedge CLK_I) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= PW'(wr_ptr + 1'b1);
      end
      if (rd_en) begin
        rd_ptr <= PW'(rd_ptr + 1'b1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= LW'(level + 1'b1);
        2'b01:   level <= LW'(level - 1'b1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prewish_mentor_q.sv
// Student strobe capture, queueing and Wishbone classic write replay towards the blinky mask registers.
//
// Input FSM
//   state   | meaning
//   IN_IDLE | waiting for synchronised STB_I rise; capture {ADR_I, DAT_I} on it
//   IN_HELD | word captured; push (or drop on overflow) at synchronised STB_I fall
// Output FSM
//   state   | meaning
//   O_IDLE  | bus quiet; launch a write when the queue holds a word
//   O_REQ   | CYC/STB/WE asserted; pop on ACK_I (or unconditionally without ACK)
//   O_GAP   | one forced idle cycle between consecutive writes
module prewish_mentor_q
  import prewish_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int USE_ACK     = 1
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     STB_I,
  input  logic [DATA_W-1:0]        DAT_I,
  input  logic [ADDR_W-1:0]        ADR_I,
  output logic                     CYC_O,
  output logic                     STB_O,
  output logic                     WE_O,
  output logic [ADDR_W-1:0]        ADR_O,
  output logic [DATA_W-1:0]        DAT_O,
  input  logic                     ACK_I,
  output logic                     OVF_O,
  output logic [lvl_w(DEPTH)-1:0]  LVL_O,
  output logic                     o_alive
);

  localparam int W = ADDR_W + DATA_W;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   stb_s;
  logic                   rise;
  logic                   fall;

  in_state_t  in_state;
  out_state_t out_state;
  logic [W-1:0] cap_q;

  logic         push_req;
  logic         push;
  logic         drop;
  logic         pop;
  logic [W-1:0] head;
  logic         fifo_full;
  logic         fifo_empty;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], STB_I};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign stb_s = sync_q[SYNC_STAGES-1];
  assign rise  = stb_s & ~prev_q;
  assign fall  = ~stb_s & prev_q;

  assign pop      = (out_state == O_REQ) && ((USE_ACK == 0) || ACK_I);
  assign push_req = (in_state == IN_HELD) && fall;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      in_state <= IN_IDLE;
      cap_q    <= '0;
      OVF_O    <= 1'b0;
      o_alive  <= 1'b1;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (rise) begin
            cap_q    <= {ADR_I, DAT_I};
            in_state <= IN_HELD;
          end
        end
        IN_HELD: begin
          if (fall) begin
            in_state <= IN_IDLE;
          end
          if (push) begin
            o_alive <= ~o_alive;
          end
          if (drop) begin
            OVF_O <= 1'b1;
          end
        end
        default: in_state <= IN_IDLE;
      endcase
    end
  end

  prewish_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (push),
    .pop   (pop),
    .din   (cap_q),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LVL_O)
  );

  // ADR_O/DAT_O are only loaded on launch so they keep the last written word while idle.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      out_state <= O_IDLE;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      ADR_O     <= '0;
      DAT_O     <= '0;
    end else begin
      case (out_state)
        O_IDLE: begin
          if (!fifo_empty) begin
            ADR_O     <= head[W-1:DATA_W];
            DAT_O     <= head[DATA_W-1:0];
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            out_state <= O_REQ;
          end
        end
        O_REQ: begin
          if (pop) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            out_state <= O_GAP;
          end
        end
        O_GAP: begin
          out_state <= O_IDLE;
        end
        default: begin
          CYC_O     <= 1'b0;
          STB_O     <= 1'b0;
          out_state <= O_IDLE;
        end
      endcase
    end
  end

  assign WE_O = STB_O;

endmodule

// File: tb/tb_prewish_mentor_q.sv
// Directed bench for prewish_mentor_q: one ACK-mode instance and one pulse-mode instance on shared student pins.
module tb_prewish_mentor_q;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       STB_I;
  logic [7:0] DAT_I;
  logic [1:0] ADR_I;
  logic       ack1;
  logic       ack0;

  logic       cyc1, stb1, we1, ovf1, alive1;
  logic [1:0] adr1;
  logic [7:0] dat1;
  logic [2:0] lvl1;

  logic       cyc0, stb0, we0, ovf0, alive0;
  logic [1:0] adr0;
  logic [7:0] dat0;
  logic [2:0] lvl0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int tot_cnt  = 0;
  logic exp_alive;

  always #5 CLK_I = ~CLK_I;

  prewish_mentor_q #(.USE_ACK(1)) dut1 (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I), .ADR_I(ADR_I),
    .CYC_O(cyc1), .STB_O(stb1), .WE_O(we1), .ADR_O(adr1), .DAT_O(dat1),
    .ACK_I(ack1), .OVF_O(ovf1), .LVL_O(lvl1), .o_alive(alive1)
  );

  prewish_mentor_q #(.USE_ACK(0)) dut0 (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I), .ADR_I(ADR_I),
    .CYC_O(cyc0), .STB_O(stb0), .WE_O(we0), .ADR_O(adr0), .DAT_O(dat0),
    .ACK_I(ack0), .OVF_O(ovf0), .LVL_O(lvl0), .o_alive(alive0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic student_write(input logic [1:0] a, input logic [7:0] d, input int hi, input int lo);
    ADR_I = a;
    DAT_I = d;
    STB_I = 1'b1;
    repeat (hi) tick();
    STB_I = 1'b0;
    repeat (lo) tick();
  endtask

  // Waits (bounded) for a strobe on the ACK-mode instance; expects ack1 held high so it lasts one cycle.
  task automatic expect_strobe(input string tag, input logic [1:0] a, input logic [7:0] d);
    int n = 0;
    while (!stb1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, " seen"}, stb1, 1);
    check({tag, " cyc"}, cyc1, 1);
    check({tag, " we"}, we1, 1);
    check({tag, " adr"}, adr1, a);
    check({tag, " dat"}, dat1, d);
    tick();
    check({tag, " gap"}, stb1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_I = 1'b0;
    STB_I = 1'b0;
    DAT_I = '0;
    ADR_I = '0;
    ack1  = 1'b0;
    ack0  = 1'b0;
    repeat (3) tick();

    check("rst cyc", cyc1, 0);
    check("rst stb", stb1, 0);
    check("rst we", we1, 0);
    check("rst adr", adr1, 0);
    check("rst dat", dat1, 0);
    check("rst ovf", ovf1, 0);
    check("rst lvl", lvl1, 0);
    check("rst alive", alive1, 1);
    RST_I = 1'b1;
    repeat (2) tick();

    // Basic ACK-mode write, latency and hold
    student_write(2'd2, 8'hA5, 5, 0);
    tick(); check("t1 e1 stb", stb1, 0);
    tick(); check("t1 e2 stb", stb1, 0);
    tick(); check("t1 e3 stb", stb1, 0);
    check("t1 e3 lvl", lvl1, 1);
    check("t1 e3 alive", alive1, 0);
    tick(); check("t1 e4 stb", stb1, 1);
    check("t1 e4 cyc", cyc1, 1);
    check("t1 e4 we", we1, 1);
    check("t1 e4 adr", adr1, 2);
    check("t1 e4 dat", dat1, 8'hA5);
    check("t1 e4 lvl", lvl1, 1);
    tick(); check("t1 e5 stb", stb1, 1);
    tick(); check("t1 e6 stb", stb1, 1);
    ack1 = 1'b1;
    tick(); check("t1 e7 stb", stb1, 0);
    check("t1 e7 cyc", cyc1, 0);
    check("t1 e7 lvl", lvl1, 0);
    check("t1 e7 dat hold", dat1, 8'hA5);
    ack1 = 1'b0;
    tick(); check("t1 e8 stb", stb1, 0);

    // Burst into a stalled slave, then overflow
    exp_alive = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      student_write(2'd0, 8'(i), 4, 4);
      exp_alive = ~exp_alive;
      check("burst lvl", lvl1, 32'(i));
      check("burst alive", alive1, exp_alive);
    end
    check("burst ovf pre", ovf1, 0);
    check("burst head stb", stb1, 1);
    student_write(2'd0, 8'h05, 4, 4);
    check("ovf set", ovf1, 1);
    check("ovf lvl", lvl1, 4);
    check("ovf alive", alive1, exp_alive);
    ack1 = 1'b1;
    expect_strobe("burst w1", 2'd0, 8'h01);
    expect_strobe("burst w2", 2'd0, 8'h02);
    expect_strobe("burst w3", 2'd0, 8'h03);
    expect_strobe("burst w4", 2'd0, 8'h04);
    tick(); tick();
    check("burst drained stb", stb1, 0);
    check("burst drained lvl", lvl1, 0);
    check("burst ovf sticky", ovf1, 1);

    // Full queue with push and pop on the same edge
    RST_I = 1'b0;
    tick();
    RST_I = 1'b1;
    tick();
    check("full ovf clr", ovf1, 0);
    ack1 = 1'b0;
    student_write(2'd3, 8'h11, 4, 4);
    student_write(2'd3, 8'h22, 4, 4);
    student_write(2'd3, 8'h33, 4, 4);
    student_write(2'd3, 8'h44, 4, 4);
    check("full lvl", lvl1, 4);
    check("full head dat", dat1, 8'h11);
    check("full alive", alive1, 1);
    ADR_I = 2'd3;
    DAT_I = 8'h55;
    STB_I = 1'b1;
    repeat (4) tick();
    STB_I = 1'b0;
    tick();
    tick();
    check("full pre lvl", lvl1, 4);
    ack1 = 1'b1;
    tick();
    check("full simul lvl", lvl1, 4);
    check("full simul ovf", ovf1, 0);
    check("full simul alive", alive1, 0);
    check("full simul stb", stb1, 0);
    expect_strobe("full w2", 2'd3, 8'h22);
    expect_strobe("full w3", 2'd3, 8'h33);
    expect_strobe("full w4", 2'd3, 8'h44);
    expect_strobe("full w5", 2'd3, 8'h55);
    check("full drained lvl", lvl1, 0);

    // Pulse mode on the USE_ACK=0 instance, ACK_I held low
    ack0 = 1'b0;
    ADR_I = 2'd1;
    DAT_I = 8'h3C;
    STB_I = 1'b1;
    repeat (4) tick();
    STB_I = 1'b0;
    repeat (3) tick();
    check("p0 e3 stb", stb0, 0);
    tick(); check("p0 e4 stb", stb0, 1);
    check("p0 e4 dat", dat0, 8'h3C);
    check("p0 e4 adr", adr0, 1);
    check("p0 e4 we", we0, 1);
    tick(); check("p0 pulse end", stb0, 0);
    check("p0 lvl", lvl0, 0);
    tick(); check("p0 idle", stb0, 0);
    ADR_I = 2'd2;
    DAT_I = 8'h5A;
    STB_I = 1'b1;
    repeat (4) tick();
    STB_I = 1'b0;
    repeat (3) tick();
    check("p1 e3 stb", stb0, 0);
    tick(); check("p1 e4 stb", stb0, 1);
    check("p1 e4 dat", dat0, 8'h5A);
    check("p1 e4 adr", adr0, 2);
    tick(); check("p1 pulse end", stb0, 0);
    check("p1 cyc end", cyc0, 0);
    check("p1 dat hold", dat0, 8'h5A);

    // Asynchronous reset in the middle of a bus cycle
    ack1 = 1'b0;
    repeat (4) tick();
    student_write(2'd1, 8'hAA, 4, 4);
    student_write(2'd1, 8'hBB, 4, 4);
    check("mid pre stb", stb1, 1);
    check("mid pre lvl", lvl1, 2);
    #2;
    RST_I = 1'b0;
    #1;
    check("mid cyc", cyc1, 0);
    check("mid stb", stb1, 0);
    check("mid we", we1, 0);
    check("mid adr", adr1, 0);
    check("mid dat", dat1, 0);
    check("mid lvl", lvl1, 0);
    check("mid ovf", ovf1, 0);
    check("mid alive", alive1, 1);
    #1;
    RST_I = 1'b1;
    repeat (10) tick();
    check("mid after stb", stb1, 0);
    check("mid after lvl", lvl1, 0);

    // Sub-clock glitch between edges, then a legal write
    STB_I = 1'b1;
    #5;
    STB_I = 1'b0;
    repeat (8) tick();
    check("glitch lvl", lvl1, 0);
    check("glitch stb", stb1, 0);
    check("glitch alive", alive1, 1);
    ack1 = 1'b1;
    student_write(2'd0, 8'hFF, 4, 4);
    expect_strobe("glitch ff", 2'd0, 8'hFF);
    check("glitch ff alive", alive1, 0);
    check("glitch ff lvl", lvl1, 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
